regfile_sb: RTL and testbench

//  Parametrised, clocked successor to the LEGv8 register file: NUM_READ combinational read ports,
//  one synchronous write port, hard-wired zero register, optional write->read bypass, and a
//  per-register busy scoreboard for the pipelined core. Sits between decode (reads, issue) and

---
 rtl/legv8_pkg.sv | 15 +
 rtl/regfile_sb_scoreboard.sv | 65 ++++++
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants and types.
//   LEGV8_DATA_W   architectural register width
//   LEGV8_NUM_REGS number of architectural registers
//   XZR_IDX        index of the hard-wired zero register
//   reg_idx_t      register index type for the default geometry
package legv8_pkg;

  localparam int LEGV8_DATA_W   = 64;
  localparam int LEGV8_NUM_REGS = 32;
  localparam int LEGV8_ADDR_W   = $clog2(LEGV8_NUM_REGS);
  localparam int XZR_IDX        = 31;

  typedef logic [LEGV8_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits for outstanding producers.
// Update priority per register, highest first: flush clears, issue sets,
// writeback clears, otherwise hold. The zero register is never busy.
//   clk, rst_n    clock, async active-low reset
//   flush         drop every outstanding producer
//   issue_valid   an instruction writing issue_rd is issued
//   issue_rd      destination of the issued instruction
//   wr_en, wr_idx writeback enable and destination
//   busy          registered busy vector
//   busy_count    registered popcount of busy (tracks busy in the same cycle)
module rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_idx,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    busy_count
);

  logic [NUM_REGS-1:0] busy_next;
  logic [CNT_W-1:0]    count_next;

  always_comb begin
    busy_next = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r == ZERO_REG) begin
        busy_next[r] = 1'b0;
      end else if (flush) begin
        busy_next[r] = 1'b0;
      end else if (issue_valid && (issue_rd == ADDR_W'(r))) begin
        // A new producer outranks a retiring one in the same cycle.
        busy_next[r] = 1'b1;
      end else if (wr_en && (wr_idx == ADDR_W'(r))) begin
        busy_next[r] = 1'b0;
      end
    end
  end

  // Counting the next vector keeps busy_count aligned with busy.
  always_comb begin
    count_next = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_next = count_next + CNT_W'(busy_next[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NUM_READ combinational read ports, one
// synchronous write port, a hard-wired zero register, optional write->read
// bypass and a busy scoreboard that flags read-after-write hazards.
//   clk, rst_n   clock, async active-low reset (clears data and busy state)
//   REG_WRITE    writeback enable
//   write_reg    writeback destination
//   writeData    writeback data
//   read_addr    packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   read_data    packed read data,    port i at [i*DATA_W +: DATA_W]
//   hazard       port i reads a register with an outstanding producer
//   issue_valid  decode issues an instruction that writes issue_rd
//   issue_rd     destination of the issued instruction
//   flush        drop all outstanding producers
//   busy_count   registered number of busy registers
module regfile_sb
  import legv8_pkg::*;
#(
  parameter int DATA_W   = LEGV8_DATA_W,
  parameter int NUM_REGS = LEGV8_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = XZR_IDX,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         REG_WRITE,
  input  logic [ADDR_W-1:0]            write_reg,
  input  logic [DATA_W-1:0]            writeData,
  input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
  output logic [NUM_READ*DATA_W-1:0]   read_data,
  output logic [NUM_READ-1:0]          hazard,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_rd,
  input  logic                         flush,
  output logic [$clog2(NUM_REGS+1)-1:0] busy_count
);

  localparam int CNT_W = $clog2(NUM_REGS+1);

  // True for an index that maps to real, writable storage.
  function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGS)) && (32'(a) != 32'(ZERO_REG));
  endfunction

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_en;

  assign wr_en = REG_WRITE && idx_ok(write_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en) begin
      regs[write_reg] <= writeData;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wr_en       (wr_en),
    .wr_idx      (write_reg),
    .busy        (busy),
    .busy_count  (busy_count)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              fwd;

    assign addr  = read_addr[i*ADDR_W +: ADDR_W];
    assign valid = idx_ok(addr);
    // A matching write this cycle both supplies the data and retires the
    // producer, so it also masks the hazard.
    assign fwd   = (BYPASS != 0) && REG_WRITE && (write_reg == addr);

    assign read_data[i*DATA_W +: DATA_W] = !valid ? '0 :
                                           fwd    ? writeData : regs[addr];
    assign hazard[i] = valid && busy[addr] && !fwd;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- DUT 1: default build (32 regs, 2 ports, bypass) -------
  logic         rst_n;
  logic         rw;
  logic [4:0]   wr;
  logic [63:0]  wd;
  logic [4:0]   ra0, ra1;
  logic [127:0] rdata;
  logic [1:0]   hz;
  logic         iv;
  logic [4:0]   ird;
  logic         fl;
  logic [5:0]   bc;

  regfile_sb u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .REG_WRITE   (rw),
    .write_reg   (wr),
    .writeData   (wd),
    .read_addr   ({ra1, ra0}),
    .read_data   (rdata),
    .hazard      (hz),
    .issue_valid (iv),
    .issue_rd    (ird),
    .flush       (fl),
    .busy_count  (bc)
  );

  // ---------------- DUT 2: 16 regs, 3 ports, no bypass, zero reg 15 -------
  logic         rst2_n;
  logic         rw2;
  logic [3:0]   wr2;
  logic [63:0]  wd2;
  logic [3:0]   ra2 [3];
  logic [191:0] rdata2;
  logic [2:0]   hz2;
  logic         iv2;
  logic [3:0]   ird2;
  logic         fl2;
  logic [4:0]   bc2;

  regfile_sb #(
    .NUM_REGS (16),
    .NUM_READ (3),
    .ZERO_REG (15),
    .BYPASS   (0)
  ) u_dut2 (
    .clk         (clk),
    .rst_n       (rst2_n),
    .REG_WRITE   (rw2),
    .write_reg   (wr2),
    .writeData   (wd2),
    .read_addr   ({ra2[2], ra2[1], ra2[0]}),
    .read_data   (rdata2),
    .hazard      (hz2),
    .issue_valid (iv2),
    .issue_rd    (ird2),
    .flush       (fl2),
    .busy_count  (bc2)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [63:0] e_rd0;
    logic [63:0] e_rd1;
    logic [1:0]  e_hz;
    logic [5:0]  e_bc;
  } vec_t;

  vec_t vecs [15];

  // Reference model for DUT 2
  logic [63:0] m_regs [16];
  logic [15:0] m_busy;
  logic [4:0]  m_cnt;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_regs[r] = '0;
    m_busy = '0;
    m_cnt  = '0;
  endtask

  task automatic idle1();
    rw = 1'b0; wr = '0; wd = '0; iv = 1'b0; ird = '0; fl = 1'b0;
  endtask

  task automatic idle2();
    rw2 = 1'b0; wr2 = '0; wd2 = '0; iv2 = 1'b0; ird2 = '0; fl2 = 1'b0;
  endtask

  initial begin
    // rw wr wd ra0 ra1 iv ird fl | rd0 rd1 hz bc   (bc = value before the edge)
    vecs[0]  = '{1'b1, 5'd5,  64'hDEAD_BEEF, 5'd5,  5'd6,  1'b0, 5'd0,  1'b0, 64'hDEAD_BEEF, 64'h0,         2'b00, 6'd0};
    vecs[1]  = '{1'b1, 5'd31, 64'h1,         5'd5,  5'd5,  1'b0, 5'd0,  1'b0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 2'b00, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  64'h0,         5'd31, 5'd5,  1'b0, 5'd0,  1'b0, 64'h0,         64'hDEAD_BEEF, 2'b00, 6'd0};
    vecs[3]  = '{1'b1, 5'd7,  64'h1234,      5'd7,  5'd31, 1'b1, 5'd3,  1'b0, 64'h1234,      64'h0,         2'b00, 6'd0};
    vecs[4]  = '{1'b0, 5'd0,  64'h0,         5'd3,  5'd7,  1'b0, 5'd0,  1'b0, 64'h0,         64'h1234,      2'b01, 6'd1};
    vecs[5]  = '{1'b1, 5'd3,  64'hAAAA,      5'd3,  5'd3,  1'b0, 5'd0,  1'b0, 64'hAAAA,      64'hAAAA,      2'b00, 6'd1};
    vecs[6]  = '{1'b0, 5'd0,  64'h0,         5'd3,  5'd0,  1'b1, 5'd9,  1'b0, 64'hAAAA,      64'h0,         2'b00, 6'd0};
    vecs[7]  = '{1'b1, 5'd9,  64'h9999,      5'd9,  5'd9,  1'b1, 5'd9,  1'b0, 64'h9999,      64'h9999,      2'b00, 6'd1};
    vecs[8]  = '{1'b0, 5'd0,  64'h0,         5'd9,  5'd3,  1'b1, 5'd1,  1'b0, 64'h9999,      64'hAAAA,      2'b01, 6'd1};
    vecs[9]  = '{1'b0, 5'd0,  64'h0,         5'd1,  5'd2,  1'b1, 5'd2,  1'b0, 64'h0,         64'h0,         2'b01, 6'd2};
    vecs[10] = '{1'b0, 5'd0,  64'h0,         5'd2,  5'd9,  1'b1, 5'd4,  1'b1, 64'h0,         64'h9999,      2'b11, 6'd3};
    vecs[11] = '{1'b0, 5'd0,  64'h0,         5'd4,  5'd1,  1'b0, 5'd0,  1'b0, 64'h0,         64'h0,         2'b00, 6'd0};
    vecs[12] = '{1'b0, 5'd0,  64'h0,         5'd31, 5'd4,  1'b1, 5'd31, 1'b0, 64'h0,         64'h0,         2'b00, 6'd0};
    vecs[13] = '{1'b0, 5'd0,  64'h0,         5'd31, 5'd9,  1'b0, 5'd0,  1'b0, 64'h0,         64'h9999,      2'b00, 6'd0};
    vecs[14] = '{1'b1, 5'd12, 64'h5555,      5'd9,  5'd12, 1'b0, 5'd0,  1'b0, 64'h9999,      64'h5555,      2'b00, 6'd0};

    rst_n = 1'b0; rst2_n = 1'b0;
    idle1(); idle2();
    ra0 = '0; ra1 = '0;
    for (int p = 0; p < 3; p++) ra2[p] = '0;
    model_reset();

    // ---- reset state of DUT 1: every index reads 0 ----
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ra0 = 5'(i); ra1 = 5'(31 - i);
      #1;
      check("reset_rd0", 192'(rdata[63:0]), 192'(0));
      check("reset_rd1", 192'(rdata[127:64]), 192'(0));
      check("reset_hz", 192'(hz), 192'(0));
      check("reset_bc", 192'(bc), 192'(0));
    end
    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;

    // ---- directed vector table ----
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      rw = vecs[v].rw; wr = vecs[v].wr; wd = vecs[v].wd;
      ra0 = vecs[v].ra0; ra1 = vecs[v].ra1;
      iv = vecs[v].iv; ird = vecs[v].ird; fl = vecs[v].fl;
      #1;
      check($sformatf("vec%0d_rd0", v), 192'(rdata[63:0]), 192'(vecs[v].e_rd0));
      check($sformatf("vec%0d_rd1", v), 192'(rdata[127:64]), 192'(vecs[v].e_rd1));
      check($sformatf("vec%0d_hz", v), 192'(hz), 192'(vecs[v].e_hz));
      check($sformatf("vec%0d_bc", v), 192'(bc), 192'(vecs[v].e_bc));
    end

    // ---- reset asserted mid-operation ----
    @(negedge clk);
    rw = 1'b1; wr = 5'd8; wd = 64'h55; iv = 1'b1; ird = 5'd6; fl = 1'b0;
    @(posedge clk);
    #1;
    idle1(); ra0 = 5'd8; ra1 = 5'd6;
    #1;
    check("pre_rst_rd0", 192'(rdata[63:0]), 192'(64'h55));
    check("pre_rst_hz", 192'(hz), 192'(2'b10));
    check("pre_rst_bc", 192'(bc), 192'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd0", 192'(rdata[63:0]), 192'(0));
    check("mid_rst_hz", 192'(hz), 192'(0));
    check("mid_rst_bc", 192'(bc), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rw = 1'b1; wr = 5'd8; wd = 64'h77; ra0 = 5'd8; ra1 = 5'd5;
    #1;
    check("post_rst_x5", 192'(rdata[127:64]), 192'(0));
    @(negedge clk);
    idle1();
    #1;
    check("post_rst_x8", 192'(rdata[63:0]), 192'(64'h77));

    // ---- DUT 2: random traffic against the reference model ----
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [191:0] e_rd;
      logic [2:0]   e_hz;
      @(negedge clk);
      if (cyc == 1000) begin
        rst2_n = 1'b0;
        idle2();
        model_reset();
        for (int k = 0; k < 6; k++) begin
          for (int p = 0; p < 3; p++) ra2[p] = 4'((3 * k + p) % 16);
          #1;
          check("r2_rst_rd", rdata2, 192'(0));
          check("r2_rst_hz", 192'(hz2), 192'(0));
          check("r2_rst_bc", 192'(bc2), 192'(0));
          @(negedge clk);
        end
        rst2_n = 1'b1;
      end
      rw2  = ($urandom_range(0, 1) == 1);
      wr2  = 4'($urandom_range(0, 15));
      wd2  = {$urandom, $urandom};
      iv2  = ($urandom_range(0, 2) != 0);
      ird2 = 4'($urandom_range(0, 15));
      fl2  = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < 3; p++) ra2[p] = 4'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < 3; p++) begin
        e_rd[p*64 +: 64] = (ra2[p] == 4'd15) ? 64'h0 : m_regs[ra2[p]];
        e_hz[p]          = (ra2[p] != 4'd15) && m_busy[ra2[p]];
      end
      check("r2_rd", rdata2, e_rd);
      check("r2_hz", 192'(hz2), 192'(e_hz));
      check("r2_bc", 192'(bc2), 192'(m_cnt));
      @(posedge clk);
      if (rw2 && wr2 != 4'd15) m_regs[wr2] = wd2;
      for (int r = 0; r < 16; r++) begin
        if (r == 15)                                m_busy[r] = 1'b0;
        else if (fl2)                               m_busy[r] = 1'b0;
        else if (iv2 && int'(ird2) == r)            m_busy[r] = 1'b1;
        else if (rw2 && int'(wr2) == r)             m_busy[r] = 1'b0;
      end
      m_cnt = '0;
      for (int r = 0; r < 16; r++) m_cnt = m_cnt + 5'(m_busy[r]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
